adc_trigger_ctrl: RTL and testbench

- Trigger/arming stage sitting directly upstream of the ADC-to-DAC capture buffer, in the ADC clock domain.
- Watches the 14-bit ADC stream for a programmable level crossing with hysteresis, or accepts a software trigger.
- On a trigger, emits a stretched pulse that drives the buffer's capture-start input.
- Waits for the buffer's capture-enable to complete, then applies a holdoff before re-arming.

---
 rtl/adc_trigger_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_adc_trigger_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_trigger_ctrl.sv
// adc_trigger_ctrl: arms on a hysteresis precondition, fires on a level
// crossing (or software trigger), stretches the capture-start pulse, waits
// for the capture buffer to finish, then applies a holdoff before re-arming.
module adc_trigger_ctrl #(
  parameter int DW        = 14,
  parameter int HOLDOFF_W = 16,
  parameter int PULSE_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        adc_i,
  input  logic                 arm_i,
  input  logic [1:0]           mode_i,
  input  logic                 sw_trig_i,
  input  logic [DW-1:0]        level_i,
  input  logic [DW-1:0]        hyst_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic                 capture_en_i,
  output logic                 trig_o,
  output logic [2:0]           state_o,
  output logic [15:0]          trig_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMING   = 3'd1,
    S_ARMED    = 3'd2,
    S_FIRE     = 3'd3,
    S_WAIT_CAP = 3'd4,
    S_HOLDOFF  = 3'd5
  } state_e;

  // One guard bit beyond DW+1 keeps level +/- hysteresis exact even when an
  // unsigned hysteresis near full scale is applied to an extreme level.
  localparam int CW = DW + 2;
  localparam int PW = 4;
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN - 1);

  state_e               state_q, state_d;
  logic [DW-1:0]        adc_q;
  logic [PW-1:0]        pulse_cnt_q, pulse_cnt_d;
  logic [HOLDOFF_W-1:0] hold_cnt_q, hold_cnt_d;
  logic                 seen_hi_q, seen_hi_d;
  logic [15:0]          trig_cnt_q, trig_cnt_d;
  logic                 trig_q, trig_d;

  logic signed [CW-1:0] adc_x, level_x, hyst_x, lo_x, hi_x;
  logic                 arm_cond, fire_cond, fire_entry;

  // Sign-extend the sample and level, zero-extend the hysteresis.
  assign adc_x   = {{2{adc_q[DW-1]}}, adc_q};
  assign level_x = {{2{level_i[DW-1]}}, level_i};
  assign hyst_x  = {2'b00, hyst_i};
  assign lo_x    = level_x - hyst_x;
  assign hi_x    = level_x + hyst_x;

  // Mode-dependent arming precondition and fire condition on adc_q.
  always_comb begin
    arm_cond  = 1'b0;
    fire_cond = 1'b0;
    case (mode_i)
      2'd0: begin
        arm_cond  = (adc_x < lo_x);
        fire_cond = (adc_x >= level_x);
      end
      2'd1: begin
        arm_cond  = (adc_x > hi_x);
        fire_cond = (adc_x <= level_x);
      end
      2'd2: begin
        arm_cond  = 1'b1;
        fire_cond = 1'b1;
      end
      2'd3: begin
        arm_cond  = 1'b1;
        fire_cond = 1'b0;
      end
      default: begin
        arm_cond  = 1'b0;
        fire_cond = 1'b0;
      end
    endcase
  end

  // Next-state logic; disarm outranks any fire request while armed/arming.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (arm_i) state_d = S_ARMING;
        else       state_d = S_IDLE;
      end
      S_ARMING: begin
        if (!arm_i)         state_d = S_IDLE;
        else if (sw_trig_i) state_d = S_FIRE;
        else if (arm_cond)  state_d = S_ARMED;
        else                state_d = S_ARMING;
      end
      S_ARMED: begin
        if (!arm_i)                       state_d = S_IDLE;
        else if (sw_trig_i || fire_cond)  state_d = S_FIRE;
        else                              state_d = S_ARMED;
      end
      S_FIRE: begin
        if (pulse_cnt_q == '0) state_d = S_WAIT_CAP;
        else                   state_d = S_FIRE;
      end
      S_WAIT_CAP: begin
        if (seen_hi_q && !capture_en_i) state_d = S_HOLDOFF;
        else                            state_d = S_WAIT_CAP;
      end
      S_HOLDOFF: begin
        if (hold_cnt_q == '0) begin
          if (arm_i) state_d = S_ARMING;
          else       state_d = S_IDLE;
        end else begin
          state_d = S_HOLDOFF;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fire_entry = (state_q != S_FIRE) && (state_d == S_FIRE);

  // Pulse, holdoff, capture-handshake and trigger counters.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    seen_hi_d   = seen_hi_q;
    trig_cnt_d  = trig_cnt_q;
    if (fire_entry) begin
      pulse_cnt_d = PULSE_LOAD;
      trig_cnt_d  = trig_cnt_q + 16'd1;
    end else if ((state_q == S_FIRE) && (pulse_cnt_q != '0)) begin
      pulse_cnt_d = pulse_cnt_q - 4'd1;
    end else begin
      pulse_cnt_d = pulse_cnt_q;
    end
    if ((state_q == S_WAIT_CAP) && (state_d == S_HOLDOFF)) begin
      hold_cnt_d = holdoff_i;
    end else if ((state_q == S_HOLDOFF) && (hold_cnt_q != '0)) begin
      hold_cnt_d = hold_cnt_q - HOLDOFF_W'(1);
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
    // A falling edge only counts after a high level has been seen here.
    if (state_d != S_WAIT_CAP) begin
      seen_hi_d = 1'b0;
    end else if (capture_en_i) begin
      seen_hi_d = 1'b1;
    end else begin
      seen_hi_d = seen_hi_q;
    end
  end

  // Output decode from the next state so trig_o is a clean flop output.
  always_comb begin
    if (state_d == S_FIRE) trig_d = 1'b1;
    else                   trig_d = 1'b0;
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      adc_q       <= '0;
      pulse_cnt_q <= '0;
      hold_cnt_q  <= '0;
      seen_hi_q   <= 1'b0;
      trig_cnt_q  <= 16'd0;
      trig_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      adc_q       <= adc_i;
      pulse_cnt_q <= pulse_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      seen_hi_q   <= seen_hi_d;
      trig_cnt_q  <= trig_cnt_d;
      trig_q      <= trig_d;
    end
  end

  assign trig_o     = trig_q;
  assign state_o    = state_q;
  assign trig_cnt_o = trig_cnt_q;

endmodule

// File: tb/tb_adc_trigger_ctrl.sv
// Directed bench for adc_trigger_ctrl with an integer behavioural model
// compared every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_adc_trigger_ctrl;

  localparam int DW = 14;
  localparam int HW = 16;
  localparam int PL = 4;

  localparam int M_IDLE   = 0;
  localparam int M_ARMING = 1;
  localparam int M_ARMED  = 2;
  localparam int M_FIRE   = 3;
  localparam int M_WAIT   = 4;
  localparam int M_HOLD   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] adc_i = '0;
  logic          arm_i = 1'b0;
  logic [1:0]    mode_i = 2'd0;
  logic          sw_trig_i = 1'b0;
  logic [DW-1:0] level_i = '0;
  logic [DW-1:0] hyst_i = '0;
  logic [HW-1:0] holdoff_i = '0;
  logic          capture_en_i = 1'b0;
  logic          trig_o;
  logic [2:0]    state_o;
  logic [15:0]   trig_cnt_o;

  int checks = 0;
  int failures = 0;

  int m_state = 0;
  int m_adc = 0;
  int m_left = 0;
  int m_hold = 0;
  int m_cnt = 0;
  bit m_seen = 1'b0;

  always #5 clk = ~clk;

  adc_trigger_ctrl #(.DW(DW), .HOLDOFF_W(HW), .PULSE_LEN(PL)) dut (
    .clk(clk), .rst(rst), .adc_i(adc_i), .arm_i(arm_i), .mode_i(mode_i),
    .sw_trig_i(sw_trig_i), .level_i(level_i), .hyst_i(hyst_i),
    .holdoff_i(holdoff_i), .capture_en_i(capture_en_i),
    .trig_o(trig_o), .state_o(state_o), .trig_cnt_o(trig_cnt_o)
  );

  // Behavioural model: plain integer arithmetic on the trigger rules.
  always @(posedge clk or posedge rst) begin : model
    int a, lvl, h;
    bit go_fire;
    if (rst) begin
      m_state = M_IDLE; m_adc = 0; m_left = 0; m_hold = 0; m_cnt = 0; m_seen = 1'b0;
    end else begin
      a = m_adc;
      lvl = int'($signed(level_i));
      h = int'(hyst_i);
      go_fire = 1'b0;
      case (m_state)
        M_IDLE: if (arm_i) m_state = M_ARMING;
        M_ARMING: begin
          if (!arm_i) m_state = M_IDLE;
          else if (sw_trig_i) go_fire = 1'b1;
          else if (mode_i >= 2'd2 || (mode_i == 2'd0 && a < lvl - h) ||
                   (mode_i == 2'd1 && a > lvl + h)) m_state = M_ARMED;
        end
        M_ARMED: begin
          if (!arm_i) m_state = M_IDLE;
          else if (sw_trig_i || mode_i == 2'd2 || (mode_i == 2'd0 && a >= lvl) ||
                   (mode_i == 2'd1 && a <= lvl)) go_fire = 1'b1;
        end
        M_FIRE: begin
          m_left = m_left - 1;
          if (m_left == 0) m_state = M_WAIT;
        end
        M_WAIT: begin
          if (capture_en_i) m_seen = 1'b1;
          else if (m_seen) begin
            m_seen = 1'b0; m_hold = int'(holdoff_i); m_state = M_HOLD;
          end
        end
        M_HOLD: begin
          if (m_hold == 0) m_state = arm_i ? M_ARMING : M_IDLE;
          else m_hold = m_hold - 1;
        end
        default: m_state = M_IDLE;
      endcase
      if (go_fire) begin
        m_state = M_FIRE; m_left = PL; m_cnt = (m_cnt + 1) % 65536;
      end
      m_adc = int'($signed(adc_i));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: compare DUT with model just after the edge, return away from it.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("mdl_state", int'(state_o), m_state);
    chk("mdl_trig", int'(trig_o), (m_state == M_FIRE) ? 1 : 0);
    chk("mdl_cnt", int'(trig_cnt_o), m_cnt);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; arm_i = 1'b0; sw_trig_i = 1'b0; capture_en_i = 1'b0;
    adc_i = '0; mode_i = 2'd0; level_i = '0; hyst_i = '0; holdoff_i = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_adc(input int v);
    adc_i = v[DW-1:0];
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int v, fire_val, hi, stray;
    bit fired;

    // Reset state
    do_reset();
    chk("reset_state", int'(state_o), 0);
    chk("reset_trig", int'(trig_o), 0);
    chk("reset_cnt", int'(trig_cnt_o), 0);

    // Rising ramp: level 1000, hyst 50
    mode_i = 2'd0; level_i = 14'd1000; hyst_i = 14'd50; arm_i = 1'b1;
    v = -2000; set_adc(v); fired = 1'b0; fire_val = 0;
    for (int i = 0; i < 400 && !fired; i++) begin
      tick();
      if (trig_o) begin fired = 1'b1; fire_val = v; end
      else begin v = v + 10; set_adc(v); end
    end
    chk("t1_fired", int'(fired), 1);
    chk("t1_fire_sample", fire_val, 1010);
    hi = 1;
    for (int i = 0; i < 10; i++) begin tick(); if (trig_o) hi++; end
    chk("t1_pulse_len", hi, 4);
    chk("t1_cnt", int'(trig_cnt_o), 1);
    chk("t1_wait_cap", int'(state_o), 4);

    // Hysteresis rejection
    do_reset();
    mode_i = 2'd0; level_i = 14'd0; hyst_i = 14'd100; arm_i = 1'b1;
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      v = (i % 2 == 1) ? 50 : -50; set_adc(v);
      tick();
      if (trig_o) hi++;
    end
    chk("t2_no_trig", hi, 0);
    chk("t2_stuck_arming", int'(state_o), 1);

    // Falling trigger, level -500, hyst 20
    do_reset();
    mode_i = 2'd1; v = -500; level_i = v[DW-1:0]; hyst_i = 14'd20; arm_i = 1'b1;
    set_adc(8191);
    tick(); tick(); tick();
    chk("t3_armed", int'(state_o), 2);
    set_adc(-479); hi = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (trig_o) hi++; end
    chk("t3_no_early", hi, 0);
    set_adc(-500);
    tick();
    chk("t3_latency_lo", int'(trig_o), 0);
    tick();
    chk("t3_fire", int'(trig_o), 1);
    do_reset();
    mode_i = 2'd1; v = -500; level_i = v[DW-1:0]; hyst_i = 14'd20; arm_i = 1'b1;
    set_adc(8191);
    tick(); tick(); tick();
    set_adc(-8192);
    tick(); tick();
    chk("t3_extreme_fire", int'(trig_o), 1);
    chk("t3_extreme_cnt", int'(trig_cnt_o), 1);

    // Full cycle with capture buffer and holdoff 100
    do_reset();
    mode_i = 2'd0; level_i = 14'd1000; hyst_i = 14'd50; holdoff_i = 16'd100; arm_i = 1'b1;
    set_adc(0);
    tick(); tick(); tick();
    set_adc(1200); fired = 1'b0;
    for (int i = 0; i < 5 && !fired; i++) begin tick(); if (trig_o) fired = 1'b1; end
    chk("t4_first_fire", int'(fired), 1);
    tick(); tick();
    capture_en_i = 1'b1;
    for (int i = 0; i < 1024; i++) tick();
    capture_en_i = 1'b0; set_adc(0); stray = 0;
    for (int k = 1; k <= 101; k++) begin tick(); if (trig_o) stray++; end
    chk("t4_holdoff_last", int'(state_o), 5);
    chk("t4_no_trig_holdoff", stray, 0);
    tick();
    chk("t4_rearm", int'(state_o), 1);
    tick();
    set_adc(1200); fired = 1'b0;
    for (int i = 0; i < 5 && !fired; i++) begin tick(); if (trig_o) fired = 1'b1; end
    chk("t4_second_fire", int'(fired), 1);
    chk("t4_cnt2", int'(trig_cnt_o), 2);

    // Software-only mode
    do_reset();
    mode_i = 2'd3; holdoff_i = 16'd20; arm_i = 1'b1; set_adc(0);
    tick(); tick();
    chk("t5_armed", int'(state_o), 2);
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      set_adc((i % 2 == 1) ? -8192 : 8191); tick(); if (trig_o) hi++;
    end
    chk("t5_no_signal_fire", hi, 0);
    sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    chk("t5_sw_fire", int'(trig_o), 1);
    for (int i = 0; i < 5; i++) tick();
    sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    chk("t5_wait_ignore", int'(state_o), 4);
    capture_en_i = 1'b1; tick(); capture_en_i = 1'b0; tick();
    chk("t5_holdoff", int'(state_o), 5);
    sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    chk("t5_holdoff_ignore", int'(state_o), 5);
    chk("t5_cnt", int'(trig_cnt_o), 1);
    fired = 1'b0;
    for (int i = 0; i < 40 && !fired; i++) begin tick(); if (state_o == 3'd2) fired = 1'b1; end
    chk("t5_rearmed", int'(fired), 1);
    arm_i = 1'b0; sw_trig_i = 1'b1; tick(); sw_trig_i = 1'b0;
    chk("t5_disarm_state", int'(state_o), 0);
    chk("t5_disarm_trig", int'(trig_o), 0);
    chk("t5_disarm_cnt", int'(trig_cnt_o), 1);

    // Reset during FIRE (immediate mode)
    do_reset();
    mode_i = 2'd2; arm_i = 1'b1; fired = 1'b0;
    for (int i = 0; i < 6 && !fired; i++) begin tick(); if (trig_o) fired = 1'b1; end
    chk("t6_fire", int'(fired), 1);
    tick();
    chk("t6_fire_c2", int'(trig_o), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_trig", int'(trig_o), 0);
    chk("t6_rst_state", int'(state_o), 0);
    chk("t6_rst_cnt", int'(trig_cnt_o), 0);
    tick();
    rst = 1'b0; arm_i = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
